apb_slave_mem: RTL and testbench

- APB3 completer: the far end of the APB bus driven by the AHB2APB sync bridge.
- Provides a word-addressed register/memory array with run-time programmable wait states and PSLVERR on illegal accesses.
- Used both as the bridge's downstream target in the sync_bridge environment and as a reusable APB endpoint.
- Also exports saturating transfer statistics for scoreboard cross-checks.

---
 rtl/apb_slave_mem_if.sv | 24 ++
 rtl/apb_slave_mem.sv | 120 ++++++++++++
 tb/tb_apb_slave_mem.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/apb_slave_mem_if.sv
// APB3 bus bundle between a requester and the apb_slave_mem completer.
interface apb_slave_mem_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_slave_mem.sv
// APB3 completer with a word-addressed memory, programmable wait states, PSLVERR on
// unaligned/out-of-range accesses and saturating transfer statistics.
module apb_slave_mem #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  apb_slave_mem_if.slave       bus,
  input  logic [3:0]           wait_cfg,
  output logic [CNT_W-1:0]     wr_cnt,
  output logic [CNT_W-1:0]     rd_cnt,
  output logic [CNT_W-1:0]     err_cnt
);
  localparam int unsigned      IdxW  = $clog2(DEPTH);
  localparam logic [ADDR_W:0]  Limit = (ADDR_W + 1)'(DEPTH * 4);

  typedef enum logic {StIdle, StAccess} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic                write_q, write_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
  logic                ready;
  logic                setup_err;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Extra MSB so DEPTH*4 == 2^ADDR_W still compares correctly.
  assign setup_err = (bus.paddr[1:0] != 2'b00) | ({1'b0, bus.paddr} >= Limit);
  assign ready     = (state_q == StAccess) && (cnt_q == 4'd0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    write_d   = write_q;
    err_d     = err_q;
    wdata_d   = wdata_q;
    mem_d     = mem_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    err_cnt_d = err_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.psel && !bus.penable) begin
          idx_d   = bus.paddr[IdxW+1:2];
          write_d = bus.pwrite;
          wdata_d = bus.pwdata;
          err_d   = setup_err;
          cnt_d   = wait_cfg;
          state_d = StAccess;
        end
      end
      StAccess: begin
        if (!bus.psel) begin
          state_d = StIdle;
        end else if (bus.penable) begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            state_d = StIdle;
            if (err_q) begin
              err_cnt_d = sat_inc(err_cnt_q);
            end else if (write_q) begin
              mem_d[idx_q] = wdata_q;
              wr_cnt_d     = sat_inc(wr_cnt_q);
            end else begin
              rd_cnt_d = sat_inc(rd_cnt_q);
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      idx_q     <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      wdata_q   <= '0;
      mem_q     <= '{default: '0};
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      write_q   <= write_d;
      err_q     <= err_d;
      wdata_q   <= wdata_d;
      mem_q     <= mem_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.pready  = ready;
  assign bus.pslverr = ready & err_q;
  assign bus.prdata  = (ready && !write_q && !err_q) ? mem_q[idx_q] : '0;
  assign wr_cnt      = wr_cnt_q;
  assign rd_cnt      = rd_cnt_q;
  assign err_cnt     = err_cnt_q;
endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: table of transfers plus reset/abort/protocol sequences.
module tb_apb_slave_mem;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  wait_cfg = 4'd0;
  logic [15:0] wr_cnt, rd_cnt, err_cnt;
  int          checks = 0;
  int          errors = 0;

  apb_slave_mem_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  apb_slave_mem #(.ADDR_W(16), .DATA_W(32), .DEPTH(64), .CNT_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .wait_cfg (wait_cfg),
    .wr_cnt   (wr_cnt),
    .rd_cnt   (rd_cnt),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  wt;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
  endtask

  // One full transfer; returns after sampling the completing access cycle.
  task automatic xfer(input string name, input logic wr, input logic [15:0] addr,
                      input logic [31:0] data, input logic [3:0] wt, input logic exp_err,
                      input logic [31:0] exp_rd);
    int waits;
    bit done;
    @(posedge clk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr;
    bus.paddr = addr; bus.pwdata = data; wait_cfg = wt;
    @(negedge clk);
    check({name, " setup pready"}, 32'(bus.pready), 32'd0);
    @(posedge clk); #1;
    // Disturb bus fields during access: latched values must be used.
    bus.penable = 1'b1; bus.paddr = ~addr; bus.pwdata = ~data; wait_cfg = 4'hf;
    waits = 0;
    done  = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (bus.pready) begin
        done = 1'b1;
      end else begin
        waits++;
        check({name, " wait prdata"}, bus.prdata, 32'd0);
        check({name, " wait pslverr"}, 32'(bus.pslverr), 32'd0);
      end
    end
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL %s timeout: pready never rose within 20 cycles", name);
    end else begin
      check({name, " wait states"}, 32'(waits), 32'(wt));
      check({name, " pslverr"}, 32'(bus.pslverr), 32'(exp_err));
      check({name, " prdata"}, bus.prdata, exp_rd);
    end
  endtask

  task automatic check_cnts(input string name, input int w, input int r, input int e);
    check({name, " wr_cnt"}, 32'(wr_cnt), 32'(w));
    check({name, " rd_cnt"}, 32'(rd_cnt), 32'(r));
    check({name, " err_cnt"}, 32'(err_cnt), 32'(e));
  endtask

  initial begin
    vecs[0]  = '{1'b1, 16'h0010, 32'hDEADBEEF, 4'd0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 16'h0010, 32'h0,        4'd0, 1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 16'h0020, 32'h0,        4'd3, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 16'h0102, 32'hBAD0BAD0, 4'd1, 1'b1, 32'h0};
    vecs[4]  = '{1'b1, 16'h0100, 32'hBAD1BAD1, 4'd0, 1'b1, 32'h0};
    vecs[5]  = '{1'b0, 16'h0100, 32'h0,        4'd2, 1'b1, 32'h0};
    vecs[6]  = '{1'b1, 16'h0004, 32'h11111111, 4'd0, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 16'h0004, 32'h0,        4'd0, 1'b0, 32'h11111111};
    vecs[8]  = '{1'b0, 16'h00FC, 32'h0,        4'd1, 1'b0, 32'h0};
    vecs[9]  = '{1'b1, 16'h00FC, 32'h12345678, 4'd2, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 16'h00FC, 32'h0,        4'd0, 1'b0, 32'h12345678};
    vecs[11] = '{1'b0, 16'h0000, 32'h0,        4'd1, 1'b0, 32'h0};

    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = '0; bus.pwdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset pready", 32'(bus.pready), 32'd0);
    check("reset pslverr", 32'(bus.pslverr), 32'd0);
    check("reset prdata", bus.prdata, 32'd0);
    check_cnts("reset", 0, 0, 0);

    // Consecutive table entries run back-to-back with no idle gap.
    for (int i = 0; i < 12; i++) begin
      xfer($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].wt,
           vecs[i].exp_err, vecs[i].exp_rd);
    end
    go_idle();
    @(negedge clk);
    check_cnts("table", 3, 6, 3);

    // Reset during the second wait cycle of a write.
    @(posedge clk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = 16'h0008; bus.pwdata = 32'hCAFEF00D; wait_cfg = 4'd5;
    @(posedge clk); #1 bus.penable = 1'b1;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("pre-reset pready", 32'(bus.pready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; bus.psel = 1'b0; bus.penable = 1'b0;
    @(negedge clk);
    check("midrst pready", 32'(bus.pready), 32'd0);
    check("midrst prdata", bus.prdata, 32'd0);
    check_cnts("midrst", 0, 0, 0);
    xfer("rd 0x08 after rst", 1'b0, 16'h0008, 32'h0, 4'd0, 1'b0, 32'h0);
    xfer("rd 0x10 after rst", 1'b0, 16'h0010, 32'h0, 4'd1, 1'b0, 32'h0);
    go_idle();

    // Drop psel in the middle of the wait states.
    @(posedge clk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = 16'h000C; bus.pwdata = 32'hA5A5A5A5; wait_cfg = 4'd4;
    @(posedge clk); #1 bus.penable = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 bus.psel = 1'b0; bus.penable = 1'b0;
    @(negedge clk);
    check("abort pready", 32'(bus.pready), 32'd0);
    xfer("rd 0x0C after abort", 1'b0, 16'h000C, 32'h0, 4'd0, 1'b0, 32'h0);
    go_idle();
    @(negedge clk);
    check_cnts("abort", 0, 3, 0);
    xfer("wr 0x0C", 1'b1, 16'h000C, 32'h5A5A5A5A, 4'd1, 1'b0, 32'h0);
    xfer("rd 0x0C", 1'b0, 16'h000C, 32'h0, 4'd0, 1'b0, 32'h5A5A5A5A);
    go_idle();
    @(negedge clk);
    check_cnts("post-abort", 1, 4, 0);

    // penable without a setup cycle must not start a transfer.
    @(posedge clk); #1 bus.psel = 1'b0; bus.penable = 1'b1;
    @(negedge clk);
    check("penable-only pready", 32'(bus.pready), 32'd0);
    @(posedge clk); #1 bus.psel = 1'b1; bus.penable = 1'b1;
    @(negedge clk);
    check("sel+en idle pready", 32'(bus.pready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("sel+en idle pready 2", 32'(bus.pready), 32'd0);
    go_idle();
    @(negedge clk);
    check_cnts("final", 1, 4, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
